// File: rtl/control_sequencer.sv
// Microcode sequencer for the 8-bit CPU: walks T0..T4 per opcode and emits the
// 16-bit datapath control word combinationally from (step, opcode, cf, zf).
module control_sequencer #(
   parameter bit HALT_ON_UNDEF = 1'b0
) (
   input  logic        clk,
   input  logic        clr,
   input  logic        en,
   input  logic [3:0]  opcode,
   input  logic        cf,
   input  logic        zf,
   output logic [15:0] ctrl,
   output logic [2:0]  step,
   output logic        halted
);

   typedef enum logic [2:0] {
      T0 = 3'd0,
      T1 = 3'd1,
      T2 = 3'd2,
      T3 = 3'd3,
      T4 = 3'd4
   } step_e;

   typedef enum logic [3:0] {
      OP_NOP = 4'h0,
      OP_LDA = 4'h1,
      OP_ADD = 4'h2,
      OP_SUB = 4'h3,
      OP_STA = 4'h4,
      OP_LDI = 4'h5,
      OP_JMP = 4'h6,
      OP_JC  = 4'h7,
      OP_JZ  = 4'h8,
      OP_OUT = 4'hE,
      OP_HLT = 4'hF
   } op_e;

   localparam logic [15:0] C_HLT = 16'h8000;
   localparam logic [15:0] C_MI  = 16'h4000;
   localparam logic [15:0] C_RI  = 16'h2000;
   localparam logic [15:0] C_RO  = 16'h1000;
   localparam logic [15:0] C_IO  = 16'h0800;
   localparam logic [15:0] C_II  = 16'h0400;
   localparam logic [15:0] C_AI  = 16'h0200;
   localparam logic [15:0] C_AO  = 16'h0100;
   localparam logic [15:0] C_EO  = 16'h0080;
   localparam logic [15:0] C_SU  = 16'h0040;
   localparam logic [15:0] C_BI  = 16'h0020;
   localparam logic [15:0] C_OI  = 16'h0010;
   localparam logic [15:0] C_CE  = 16'h0008;
   localparam logic [15:0] C_CO  = 16'h0004;
   localparam logic [15:0] C_J   = 16'h0002;
   localparam logic [15:0] C_FI  = 16'h0001;

   step_e       step_q, step_d;
   logic [15:0] ctrl_raw;
   logic        last;
   logic        undef_op;
   op_e         op;

   assign op       = op_e'(opcode);
   assign undef_op = (opcode >= 4'h9) && (opcode <= 4'hD);

   always_comb begin
      ctrl_raw = '0;
      last     = 1'b0;
      case (step_q)
         T0: ctrl_raw = C_CO | C_MI;
         T1: begin
            ctrl_raw = C_RO | C_II | C_CE;
            last     = (op == OP_NOP) || (undef_op && !HALT_ON_UNDEF);
         end
         T2: begin
            case (op)
               OP_LDA, OP_ADD, OP_SUB, OP_STA: ctrl_raw = C_IO | C_MI;
               OP_LDI: begin ctrl_raw = C_IO | C_AI; last = 1'b1; end
               OP_JMP: begin ctrl_raw = C_IO | C_J;  last = 1'b1; end
               OP_JC:  begin ctrl_raw = cf ? (C_IO | C_J) : '0; last = 1'b1; end
               OP_JZ:  begin ctrl_raw = zf ? (C_IO | C_J) : '0; last = 1'b1; end
               OP_OUT: begin ctrl_raw = C_AO | C_OI; last = 1'b1; end
               OP_HLT: begin ctrl_raw = C_HLT; last = 1'b1; end
               default: begin
                  // Only reachable for undefined opcodes when they behave as HLT.
                  ctrl_raw = (undef_op && HALT_ON_UNDEF) ? C_HLT : '0;
                  last     = 1'b1;
               end
            endcase
         end
         T3: begin
            case (op)
               OP_LDA:         begin ctrl_raw = C_RO | C_AI; last = 1'b1; end
               OP_ADD, OP_SUB: ctrl_raw = C_RO | C_BI;
               OP_STA:         begin ctrl_raw = C_AO | C_RI; last = 1'b1; end
               default:        last = 1'b1;
            endcase
         end
         T4: begin
            last = 1'b1;
            case (op)
               OP_ADD:  ctrl_raw = C_EO | C_AI | C_FI;
               OP_SUB:  ctrl_raw = C_EO | C_AI | C_SU | C_FI;
               default: ctrl_raw = '0;
            endcase
         end
         default: last = 1'b1;
      endcase
   end

   always_comb begin
      step_d = step_q;
      if (en && !ctrl_raw[15]) begin
         step_d = last ? T0 : step_e'(step_q + 3'd1);
      end
   end

   always_ff @(posedge clk or posedge clr) begin
      if (clr) step_q <= T0;
      else     step_q <= step_d;
   end

   assign ctrl   = clr ? '0 : ctrl_raw;
   assign halted = ctrl[15];
   assign step   = step_q;

endmodule

// File: tb/tb_control_sequencer.sv
// Scoreboard bench for control_sequencer: each cycle's stimulus and expected
// (step, ctrl) are queued, then replayed and compared one cycle at a time.
module tb_control_sequencer;

   typedef struct packed {
      logic        en;
      logic [3:0]  op;
      logic        cf;
      logic        zf;
      logic [2:0]  st;
      logic [15:0] ctrl;
   } ent_t;

   logic        clk = 1'b0;
   logic        clr = 1'b1;
   logic        en = 1'b1;
   logic [3:0]  opcode = 4'h0;
   logic        cf = 1'b0;
   logic        zf = 1'b0;
   logic [15:0] ctrl, ctrl_h;
   logic [2:0]  step, step_h;
   logic        halted, halted_h;

   int unsigned n_cmp = 0;
   int unsigned n_err = 0;
   ent_t        sb[$];
   ent_t        e;

   control_sequencer #(.HALT_ON_UNDEF(1'b0)) dut (
      .clk(clk), .clr(clr), .en(en), .opcode(opcode), .cf(cf), .zf(zf),
      .ctrl(ctrl), .step(step), .halted(halted)
   );

   control_sequencer #(.HALT_ON_UNDEF(1'b1)) dut_h (
      .clk(clk), .clr(clr), .en(en), .opcode(opcode), .cf(cf), .zf(zf),
      .ctrl(ctrl_h), .step(step_h), .halted(halted_h)
   );

   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit expired");
      $fatal(1, "watchdog");
   end

   function automatic void push(input logic pe, input logic [3:0] po, input logic pc,
                                input logic pz, input logic [2:0] ps, input logic [15:0] pk);
      ent_t x;
      x.en = pe; x.op = po; x.cf = pc; x.zf = pz; x.st = ps; x.ctrl = pk;
      sb.push_back(x);
   endfunction

   // Called at a falling edge; leaves the DUT at T0 on the current falling edge.
   task automatic do_clr();
      clr = 1'b1;
      @(negedge clk);
      clr = 1'b0;
   endtask

   task automatic test_reset();
      @(negedge clk);
      clr = 1'b1; en = 1'b1; opcode = 4'h1;
      #1;
      n_cmp++;
      if (step !== 3'd0 || ctrl !== 16'h0000 || halted !== 1'b0) begin
         n_err++;
         $display("FAIL reset: step=%0d ctrl=%h halted=%b, want step=0 ctrl=0000 halted=0",
                  step, ctrl, halted);
      end
      @(negedge clk);
      clr = 1'b0;
   endtask

   task automatic test_lda();
      do_clr();
      push(1, 4'h1, 0, 0, 0, 16'h4004);
      push(1, 4'h1, 0, 0, 1, 16'h1408);
      push(1, 4'h1, 0, 0, 2, 16'h4800);
      push(1, 4'h1, 0, 0, 3, 16'h1200);
      push(1, 4'h1, 0, 0, 0, 16'h4004);
      while (sb.size() > 0) begin
         e = sb.pop_front();
         en = e.en; opcode = e.op; cf = e.cf; zf = e.zf;
         #1;
         n_cmp++;
         if (step !== e.st || ctrl !== e.ctrl || halted !== e.ctrl[15]) begin
            n_err++;
            $display("FAIL lda: step=%0d ctrl=%h halted=%b, want step=%0d ctrl=%h",
                     step, ctrl, halted, e.st, e.ctrl);
         end
         @(negedge clk);
      end
   endtask

   task automatic test_alu(input logic [3:0] op, input logic [15:0] t4);
      do_clr();
      push(1, op, 0, 0, 0, 16'h4004);
      push(1, op, 0, 0, 1, 16'h1408);
      push(1, op, 1, 1, 2, 16'h4800);
      push(1, op, 0, 1, 3, 16'h1020);
      push(1, op, 1, 0, 4, t4);
      push(1, op, 0, 0, 0, 16'h4004);
      while (sb.size() > 0) begin
         e = sb.pop_front();
         en = e.en; opcode = e.op; cf = e.cf; zf = e.zf;
         #1;
         n_cmp++;
         if (step !== e.st || ctrl !== e.ctrl || halted !== e.ctrl[15]) begin
            n_err++;
            $display("FAIL alu op=%h: step=%0d ctrl=%h, want step=%0d ctrl=%h",
                     op, step, ctrl, e.st, e.ctrl);
         end
         @(negedge clk);
      end
   endtask

   task automatic test_jumps();
      for (int i = 0; i < 6; i++) begin
         logic [3:0]  op;
         logic        c, z;
         logic [15:0] t2;
         op = (i < 3) ? 4'h7 : 4'h8;
         c  = (i == 0) || (i == 2) || (i == 5);
         z  = (i == 1) || (i == 3);
         // JC follows cf only, JZ follows zf only.
         t2 = (op == 4'h7) ? (c ? 16'h0802 : 16'h0000) : (z ? 16'h0802 : 16'h0000);
         do_clr();
         push(1, op, c, z, 0, 16'h4004);
         push(1, op, c, z, 1, 16'h1408);
         push(1, op, c, z, 2, t2);
         push(1, op, c, z, 0, 16'h4004);
         while (sb.size() > 0) begin
            e = sb.pop_front();
            en = e.en; opcode = e.op; cf = e.cf; zf = e.zf;
            #1;
            n_cmp++;
            if (step !== e.st || ctrl !== e.ctrl || halted !== e.ctrl[15]) begin
               n_err++;
               $display("FAIL jump op=%h cf=%b zf=%b: step=%0d ctrl=%h, want step=%0d ctrl=%h",
                        op, c, z, step, ctrl, e.st, e.ctrl);
            end
            @(negedge clk);
         end
      end
   endtask

   task automatic test_misc();
      do_clr();
      push(1, 4'h0, 0, 0, 0, 16'h4004);
      push(1, 4'h0, 0, 0, 1, 16'h1408);
      push(1, 4'h4, 0, 0, 0, 16'h4004);
      push(1, 4'h4, 0, 0, 1, 16'h1408);
      push(1, 4'h4, 0, 0, 2, 16'h4800);
      push(1, 4'h4, 0, 0, 3, 16'h2100);
      push(1, 4'h5, 0, 0, 0, 16'h4004);
      push(1, 4'h5, 0, 0, 1, 16'h1408);
      push(1, 4'h5, 0, 0, 2, 16'h0A00);
      push(1, 4'h6, 0, 0, 0, 16'h4004);
      push(1, 4'h6, 0, 0, 1, 16'h1408);
      push(1, 4'h6, 0, 0, 2, 16'h0802);
      push(1, 4'hE, 0, 0, 0, 16'h4004);
      push(1, 4'hE, 0, 0, 1, 16'h1408);
      push(1, 4'hE, 0, 0, 2, 16'h0110);
      push(1, 4'hB, 0, 0, 0, 16'h4004);
      push(1, 4'hB, 0, 0, 1, 16'h1408);
      push(1, 4'hB, 0, 0, 0, 16'h4004);
      while (sb.size() > 0) begin
         e = sb.pop_front();
         en = e.en; opcode = e.op; cf = e.cf; zf = e.zf;
         #1;
         n_cmp++;
         if (step !== e.st || ctrl !== e.ctrl || halted !== e.ctrl[15]) begin
            n_err++;
            $display("FAIL misc op=%h: step=%0d ctrl=%h, want step=%0d ctrl=%h",
                     e.op, step, ctrl, e.st, e.ctrl);
         end
         @(negedge clk);
      end
   endtask

   task automatic test_halt();
      do_clr();
      push(1, 4'hF, 0, 0, 0, 16'h4004);
      push(1, 4'hF, 0, 0, 1, 16'h1408);
      push(1, 4'hF, 0, 0, 2, 16'h8000);
      for (int i = 0; i < 10; i++) push(logic'(i % 2), 4'hF, 0, 0, 2, 16'h8000);
      while (sb.size() > 0) begin
         e = sb.pop_front();
         en = e.en; opcode = e.op; cf = e.cf; zf = e.zf;
         #1;
         n_cmp++;
         if (step !== e.st || ctrl !== e.ctrl || halted !== e.ctrl[15]) begin
            n_err++;
            $display("FAIL halt: step=%0d ctrl=%h halted=%b, want step=%0d ctrl=%h",
                     step, ctrl, halted, e.st, e.ctrl);
         end
         @(negedge clk);
      end
      en = 1'b1;
      clr = 1'b1;
      #1;
      n_cmp++;
      if (step !== 3'd0 || ctrl !== 16'h0000 || halted !== 1'b0) begin
         n_err++;
         $display("FAIL halt_clr: step=%0d ctrl=%h halted=%b, want 0 0000 0", step, ctrl, halted);
      end
      @(negedge clk);
      clr = 1'b0;
      #1;
      n_cmp++;
      if (step !== 3'd0 || ctrl !== 16'h4004 || halted !== 1'b0) begin
         n_err++;
         $display("FAIL halt_release: step=%0d ctrl=%h halted=%b, want 0 4004 0", step, ctrl, halted);
      end
      @(negedge clk);
   endtask

   task automatic test_en_hold();
      do_clr();
      push(1, 4'h1, 0, 0, 0, 16'h4004);
      push(1, 4'h1, 0, 0, 1, 16'h1408);
      push(1, 4'h1, 0, 0, 2, 16'h4800);
      push(0, 4'h1, 0, 0, 3, 16'h1200);
      push(0, 4'h1, 0, 0, 3, 16'h1200);
      push(0, 4'h1, 0, 0, 3, 16'h1200);
      push(1, 4'h1, 0, 0, 3, 16'h1200);
      push(1, 4'h1, 0, 0, 0, 16'h4004);
      while (sb.size() > 0) begin
         e = sb.pop_front();
         en = e.en; opcode = e.op; cf = e.cf; zf = e.zf;
         #1;
         n_cmp++;
         if (step !== e.st || ctrl !== e.ctrl || halted !== e.ctrl[15]) begin
            n_err++;
            $display("FAIL en_hold: step=%0d ctrl=%h, want step=%0d ctrl=%h",
                     step, ctrl, e.st, e.ctrl);
         end
         @(negedge clk);
      end
   endtask

   task automatic test_async_clr();
      do_clr();
      push(1, 4'h2, 0, 0, 0, 16'h4004);
      push(1, 4'h2, 0, 0, 1, 16'h1408);
      push(1, 4'h2, 0, 0, 2, 16'h4800);
      push(1, 4'h2, 0, 0, 3, 16'h1020);
      while (sb.size() > 0) begin
         e = sb.pop_front();
         en = e.en; opcode = e.op; cf = e.cf; zf = e.zf;
         #1;
         n_cmp++;
         if (step !== e.st || ctrl !== e.ctrl || halted !== e.ctrl[15]) begin
            n_err++;
            $display("FAIL async_pre: step=%0d ctrl=%h, want step=%0d ctrl=%h",
                     step, ctrl, e.st, e.ctrl);
         end
         if (e.st == 3'd3) begin
            #2 clr = 1'b1;
            #1;
            n_cmp++;
            if (step !== 3'd0 || ctrl !== 16'h0000 || halted !== 1'b0) begin
               n_err++;
               $display("FAIL async_clr: step=%0d ctrl=%h halted=%b, want 0 0000 0",
                        step, ctrl, halted);
            end
         end
         @(negedge clk);
      end
      clr = 1'b0;
      #1;
      n_cmp++;
      if (step !== 3'd0 || ctrl !== 16'h4004) begin
         n_err++;
         $display("FAIL async_release: step=%0d ctrl=%h, want 0 4004", step, ctrl);
      end
      @(negedge clk);
   endtask

   task automatic test_undef_halt();
      logic [2:0]  hs [4];
      logic [15:0] hc [4];
      hs = '{3'd0, 3'd1, 3'd2, 3'd2};
      hc = '{16'h4004, 16'h1408, 16'h8000, 16'h8000};
      do_clr();
      push(1, 4'hA, 0, 0, 0, 16'h4004);
      push(1, 4'hA, 0, 0, 1, 16'h1408);
      push(1, 4'hA, 0, 0, 0, 16'h4004);
      push(1, 4'hA, 0, 0, 1, 16'h1408);
      for (int i = 0; i < 4; i++) begin
         e = sb.pop_front();
         en = e.en; opcode = e.op; cf = e.cf; zf = e.zf;
         #1;
         n_cmp++;
         if (step !== e.st || ctrl !== e.ctrl) begin
            n_err++;
            $display("FAIL undef_nop: step=%0d ctrl=%h, want step=%0d ctrl=%h",
                     step, ctrl, e.st, e.ctrl);
         end
         n_cmp++;
         if (step_h !== hs[i] || ctrl_h !== hc[i] || halted_h !== hc[i][15]) begin
            n_err++;
            $display("FAIL undef_hlt: step=%0d ctrl=%h halted=%b, want step=%0d ctrl=%h",
                     step_h, ctrl_h, halted_h, hs[i], hc[i]);
         end
         @(negedge clk);
      end
   endtask

   initial begin
      test_reset();
      test_lda();
      test_alu(4'h3, 16'h02C1);
      test_alu(4'h2, 16'h0281);
      test_jumps();
      test_misc();
      test_halt();
      test_en_hold();
      test_async_clr();
      test_undef_halt();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
